// File: rtl/hack_pkg.sv
// Shared Hack memory-hierarchy definitions: word/address widths and the RAM8 sweep FSM states.
package hack_pkg;

  localparam int unsigned WORD_W      = 16;
  localparam int unsigned RAM8_ADDR_W = 3;
  localparam int unsigned RAM8_DEPTH  = 8;

  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } ram8_state_t;

endpackage

// File: rtl/hack_mux8way16.sv
// 8-way word multiplexer; purely combinational read select.
module hack_mux8way16
  import hack_pkg::*;
#(
  parameter int unsigned WIDTH = WORD_W
) (
  input  logic [RAM8_DEPTH-1:0][WIDTH-1:0] i_d,
  input  logic [RAM8_ADDR_W-1:0]           i_sel,
  output logic [WIDTH-1:0]                 o_y_c
);

  assign o_y_c = i_d[i_sel];

endmodule

// File: rtl/hack_register16.sv
// Single storage word with load enable and asynchronous active-high reset.
module hack_register16
  import hack_pkg::*;
#(
  parameter int unsigned WIDTH = WORD_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_load,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q
);

  logic [WIDTH-1:0] r_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_q <= '0;
    end else if (i_load) begin
      r_q <= i_d;
    end
  end

  assign o_q = r_q;

endmodule

// File: rtl/ram8_bank.sv
// 8 x 16-bit register bank with a hardware clear sweep, busy flag and sticky dropped-write flag.
// Define RAM8_BYPASS_EN for write-through / sweep-through on the read path.
module ram8_bank
  import hack_pkg::*;
#(
  parameter int unsigned     WIDTH     = WORD_W,
  parameter logic [WIDTH-1:0] CLEAR_VAL = '0
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [WIDTH-1:0]       in,
  input  logic                   load,
  input  logic [RAM8_ADDR_W-1:0] address,
  input  logic                   clear,
  output logic [WIDTH-1:0]       out,
  output logic                   busy,
  output logic                   load_drop
);

  ram8_state_t                      r_state;
  ram8_state_t                      w_state_nxt;
  logic [RAM8_ADDR_W-1:0]           r_idx;
  logic [RAM8_ADDR_W-1:0]           w_idx_nxt;
  logic                             r_load_drop;
  logic                             w_load_drop_nxt;
  logic                             w_busy;
  logic [RAM8_DEPTH-1:0]            w_word_load;
  logic [WIDTH-1:0]                 w_word_d;
  logic [RAM8_DEPTH-1:0][WIDTH-1:0] w_words;
  logic [WIDTH-1:0]                 w_mux_out;

  assign w_busy = (r_state == CLEAR);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= IDLE;
      r_idx       <= '0;
      r_load_drop <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_idx       <= w_idx_nxt;
      r_load_drop <= w_load_drop_nxt;
    end
  end

  // Sweep sequencing: clear is only honoured in IDLE, so a sweep is never restarted or extended.
  always_comb begin
    w_state_nxt     = r_state;
    w_idx_nxt       = r_idx;
    w_load_drop_nxt = r_load_drop | (load & w_busy);
    case (r_state)
      IDLE: begin
        if (clear) begin
          w_state_nxt = CLEAR;
          w_idx_nxt   = '0;
        end
      end
      CLEAR: begin
        w_idx_nxt = RAM8_ADDR_W'(r_idx + 1'b1);
        if (r_idx == RAM8_ADDR_W'(RAM8_DEPTH - 1)) begin
          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  assign w_word_d = w_busy ? CLEAR_VAL : in;

  for (genvar i = 0; i < RAM8_DEPTH; i++) begin : g_word
    assign w_word_load[i] = (load & ~w_busy & (address == RAM8_ADDR_W'(i)))
                          | (w_busy & (r_idx == RAM8_ADDR_W'(i)));

    hack_register16 #(.WIDTH(WIDTH)) u_reg (
      .clk    (clk),
      .rst    (reset),
      .i_load (w_word_load[i]),
      .i_d    (w_word_d),
      .o_q    (w_words[i])
    );
  end

  hack_mux8way16 #(.WIDTH(WIDTH)) u_mux (
    .i_d   (w_words),
    .i_sel (address),
    .o_y_c (w_mux_out)
  );

`ifdef RAM8_BYPASS_EN
  // Show the value that will be stored at the coming edge.
  always_comb begin
    out = w_mux_out;
    if (load && !w_busy) begin
      out = in;
    end else if (w_busy && (address == r_idx)) begin
      out = CLEAR_VAL;
    end
  end
`else
  assign out = w_mux_out;
`endif

  assign busy      = w_busy;
  assign load_drop = r_load_drop;

endmodule

// File: tb/tb_ram8_bank.sv
// Directed, table-driven bench for ram8_bank plus hand sequences for async reset and sweep length.
module tb_ram8_bank;

  typedef struct {
    logic        ld;
    logic [2:0]  a;
    logic [15:0] d;
    logic        clr;
    logic [15:0] eo;
    logic [15:0] eb;
    logic        ebusy;
    logic        edrop;
  } vec_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        load;
  logic        clear;
  logic [15:0] din;
  logic [2:0]  address;
  logic [15:0] dout;
  logic        busy;
  logic        load_drop;

  int total = 0;
  int bad   = 0;
  vec_t vecs[$];

  always #5 clk = ~clk;

  ram8_bank dut (
    .clk       (clk),
    .reset     (reset),
    .in        (din),
    .load      (load),
    .address   (address),
    .clear     (clear),
    .out       (dout),
    .busy      (busy),
    .load_drop (load_drop)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic add(input logic ld, input logic [2:0] a, input logic [15:0] d, input logic clr,
                     input logic [15:0] eo, input logic [15:0] eb, input logic ebusy, input logic edrop);
    vec_t v;
    v.ld = ld; v.a = a; v.d = d; v.clr = clr;
    v.eo = eo; v.eb = eb; v.ebusy = ebusy; v.edrop = edrop;
    vecs.push_back(v);
  endtask

  // Drive at the falling edge, settle 1 time unit before sampling.
  task automatic drive(input logic ld, input logic [2:0] a, input logic [15:0] d, input logic clr);
    @(negedge clk);
    load = ld; address = a; din = d; clear = clr;
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] fill;
    logic [15:0] exp_out;
    int          cnt;

    reset = 1'b1; load = 1'b0; clear = 1'b0; din = '0; address = '0;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_out", 32'(dout), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_drop", 32'(load_drop), 32'h0);
    reset = 1'b0;

    // Write/read at address 5
    add(1, 3'd5, 16'hBEEF, 0, 16'h0000, 16'hBEEF, 0, 0);
    add(0, 3'd5, 16'h0000, 0, 16'hBEEF, 16'hBEEF, 0, 0);
    add(0, 3'd4, 16'h0000, 0, 16'h0000, 16'h0000, 0, 0);
    // Fill 0..7 then read back
    for (int i = 0; i < 8; i++) begin
      fill = 16'(16'h1111 * (i + 1));
      add(1, 3'(i), fill, 0, (i == 5) ? 16'hBEEF : 16'h0000, fill, 0, 0);
    end
    for (int i = 0; i < 8; i++) begin
      fill = 16'(16'h1111 * (i + 1));
      add(0, 3'(i), 16'h0000, 0, fill, fill, 0, 0);
    end
    // Sweep with a dropped write at sweep cycle 3 and a re-pulsed clear at cycle 4
    add(0, 3'd0, 16'h0000, 1, 16'h1111, 16'h1111, 0, 0);
    add(0, 3'd7, 16'h0000, 0, 16'h8888, 16'h8888, 1, 0);
    add(0, 3'd0, 16'h0000, 0, 16'h0000, 16'h0000, 1, 0);
    add(0, 3'd1, 16'h0000, 0, 16'h0000, 16'h0000, 1, 0);
    add(1, 3'd7, 16'hAAAA, 0, 16'h8888, 16'h8888, 1, 0);
    add(0, 3'd7, 16'h0000, 1, 16'h8888, 16'h8888, 1, 1);
    add(0, 3'd6, 16'h0000, 0, 16'h7777, 16'h7777, 1, 1);
    add(0, 3'd6, 16'h0000, 0, 16'h7777, 16'h0000, 1, 1);
    add(0, 3'd7, 16'h0000, 0, 16'h8888, 16'h0000, 1, 1);
    add(0, 3'd7, 16'h0000, 0, 16'h0000, 16'h0000, 0, 1);
    add(0, 3'd2, 16'h0000, 0, 16'h0000, 16'h0000, 0, 1);
    add(0, 3'd5, 16'h0000, 0, 16'h0000, 16'h0000, 0, 1);
    // Simultaneous load and clear in IDLE
    add(1, 3'd2, 16'h1234, 1, 16'h0000, 16'h1234, 0, 1);
    add(0, 3'd2, 16'h0000, 0, 16'h1234, 16'h1234, 1, 1);
    add(0, 3'd2, 16'h0000, 0, 16'h1234, 16'h1234, 1, 1);
    add(0, 3'd2, 16'h0000, 0, 16'h1234, 16'h0000, 1, 1);
    for (int i = 0; i < 5; i++) add(0, 3'd2, 16'h0000, 0, 16'h0000, 16'h0000, 1, 1);
    add(0, 3'd2, 16'h0000, 0, 16'h0000, 16'h0000, 0, 1);

    foreach (vecs[k]) begin
      drive(vecs[k].ld, vecs[k].a, vecs[k].d, vecs[k].clr);
`ifdef RAM8_BYPASS_EN
      exp_out = vecs[k].eb;
`else
      exp_out = vecs[k].eo;
`endif
      chk($sformatf("v%0d_out", k), 32'(dout), 32'(exp_out));
      chk($sformatf("v%0d_busy", k), 32'(busy), 32'(vecs[k].ebusy));
      chk($sformatf("v%0d_drop", k), 32'(load_drop), 32'(vecs[k].edrop));
    end

    // Async reset mid-cycle with a preloaded word and load_drop set
    drive(1, 3'd3, 16'h5A5A, 0);
    drive(0, 3'd3, 16'h0000, 0);
    chk("pre_rst_out", 32'(dout), 32'h5A5A);
    reset = 1'b1;
    #1;
    chk("async_rst_out", 32'(dout), 32'h0);
    chk("async_rst_busy", 32'(busy), 32'h0);
    chk("async_rst_drop", 32'(load_drop), 32'h0);
    for (int a = 0; a < 8; a++) begin
      address = 3'(a);
      #1;
      chk($sformatf("rst_addr%0d", a), 32'(dout), 32'h0);
    end
    @(negedge clk);
    reset = 1'b0;

    // Reset in the middle of a sweep
    drive(0, 3'd0, 16'h0000, 1);
    for (int k = 0; k < 5; k++) begin
      drive(0, 3'd0, 16'h0000, 0);
      chk($sformatf("mid_sweep_busy%0d", k), 32'(busy), 32'h1);
    end
    reset = 1'b1;
    #1;
    chk("mid_sweep_rst_busy", 32'(busy), 32'h0);
    @(negedge clk);
    reset = 1'b0;
    drive(0, 3'd0, 16'h0000, 0);
    chk("post_rst_idle", 32'(busy), 32'h0);

    // Full sweep after reset; a clear re-pulse must not extend it
    drive(0, 3'd0, 16'h0000, 1);
    cnt = 0;
    for (int k = 0; k < 20; k++) begin
      drive(0, 3'd3, 16'h0000, (k == 2));
      if (busy) cnt++;
    end
    chk("sweep_len", 32'(cnt), 32'd8);
    chk("sweep_end_busy", 32'(busy), 32'h0);
    chk("sweep_end_out", 32'(dout), 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
